// File: rtl/fpu_arbiter_if.sv
// Bundle of requester-side and FPU-side handshake signals around the FPU arbiter.
// The slave modport is the arbiter's view; master is the cores-plus-FPU environment.
interface fpu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OPE_W  = 4
);
  // requester 0
  logic [OPE_W-1:0]  r0_ope;
  logic [DATA_W-1:0] r0_in1;
  logic [DATA_W-1:0] r0_in2;
  logic              r0_in_vld;
  logic              r0_in_rdy;
  logic [DATA_W-1:0] r0_out_data;
  logic [2:0]        r0_out_err;
  logic              r0_out_vld;
  logic              r0_out_rdy;
  // requester 1
  logic [OPE_W-1:0]  r1_ope;
  logic [DATA_W-1:0] r1_in1;
  logic [DATA_W-1:0] r1_in2;
  logic              r1_in_vld;
  logic              r1_in_rdy;
  logic [DATA_W-1:0] r1_out_data;
  logic [2:0]        r1_out_err;
  logic              r1_out_vld;
  logic              r1_out_rdy;
  // shared FPU
  logic [OPE_W-1:0]  f_ope_data;
  logic [DATA_W-1:0] f_in1_data;
  logic [DATA_W-1:0] f_in2_data;
  logic              f_in_vld;
  logic              f_in_rdy;
  logic [DATA_W-1:0] f_out_data;
  logic              f_out_vld;
  logic              f_out_rdy;
  logic [2:0]        f_err;

  modport slave (
    input  r0_ope, r0_in1, r0_in2, r0_in_vld, r0_out_rdy,
    input  r1_ope, r1_in1, r1_in2, r1_in_vld, r1_out_rdy,
    output r0_in_rdy, r0_out_data, r0_out_err, r0_out_vld,
    output r1_in_rdy, r1_out_data, r1_out_err, r1_out_vld,
    output f_ope_data, f_in1_data, f_in2_data, f_in_vld, f_out_rdy,
    input  f_in_rdy, f_out_data, f_out_vld, f_err
  );

  modport master (
    output r0_ope, r0_in1, r0_in2, r0_in_vld, r0_out_rdy,
    output r1_ope, r1_in1, r1_in2, r1_in_vld, r1_out_rdy,
    input  r0_in_rdy, r0_out_data, r0_out_err, r0_out_vld,
    input  r1_in_rdy, r1_out_data, r1_out_err, r1_out_vld,
    input  f_ope_data, f_in1_data, f_in2_data, f_in_vld, f_out_rdy,
    output f_in_rdy, f_out_data, f_out_vld, f_err
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between two requesters, one op in flight,
// with a per-op watchdog that returns an error result if the FPU hangs.
module fpu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OPE_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  fpu_arbiter_if.slave      bus,
  input  logic              err_clr,
  output logic [3:0]        arb_err
);
  localparam int                WDOG_W    = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [OPE_W-1:0]  f_ope_q, f_ope_d;
  logic [DATA_W-1:0] f_in1_q, f_in1_d;
  logic [DATA_W-1:0] f_in2_q, f_in2_d;
  logic              f_in_vld_q, f_in_vld_d;
  logic              f_out_rdy_q, f_out_rdy_d;
  logic [DATA_W-1:0] out_data_q [2];
  logic [DATA_W-1:0] out_data_d [2];
  logic [2:0]        out_err_q [2];
  logic [2:0]        out_err_d [2];
  logic [1:0]        out_vld_q, out_vld_d;
  logic [3:0]        arb_err_q, arb_err_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic [1:0]        req_vld, in_rdy, out_rdy;
  logic              grant, grant_vld, accept;
  logic              f_in_hs, f_out_hs, expire, abort, owner_rdy;
  logic [OPE_W-1:0]  req_ope;
  logic [DATA_W-1:0] req_in1, req_in2;

  assign req_vld = {bus.r1_in_vld, bus.r0_in_vld};
  assign out_rdy = {bus.r1_out_rdy, bus.r0_out_rdy};

  // With both requesting, the one that did not own the previous op wins.
  always_comb begin
    grant_vld = |req_vld;
    grant     = (req_vld == 2'b11) ? ~last_q : req_vld[1];
  end

  assign in_rdy    = (state_q == IDLE && grant_vld) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(in_rdy & req_vld);
  assign req_ope   = grant ? bus.r1_ope : bus.r0_ope;
  assign req_in1   = grant ? bus.r1_in1 : bus.r0_in1;
  assign req_in2   = grant ? bus.r1_in2 : bus.r0_in2;
  assign f_in_hs   = f_in_vld_q & bus.f_in_rdy;
  assign f_out_hs  = bus.f_out_vld & f_out_rdy_q;
  assign expire    = (wdog_q == WDOG_LAST);
  assign owner_rdy = out_rdy[owner_q];

  // A handshake landing on the expiry cycle takes the normal path.
  assign abort = expire && ((state_q == ISSUE && !f_in_hs) || (state_q == WAIT && !f_out_hs));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (f_in_hs) state_d = WAIT;
               else if (abort) state_d = RESP;
      WAIT:    if (f_out_hs || abort) state_d = RESP;
      RESP:    if (owner_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    f_ope_d     = f_ope_q;
    f_in1_d     = f_in1_q;
    f_in2_d     = f_in2_q;
    f_in_vld_d  = f_in_vld_q;
    f_out_rdy_d = f_out_rdy_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_vld_d   = out_vld_q;
    wdog_d      = wdog_q;
    arb_err_d   = err_clr ? 4'b0000 : arb_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f_ope_d    = req_ope;
          f_in1_d    = req_in1;
          f_in2_d    = req_in2;
          owner_d    = grant;
          f_in_vld_d = 1'b1;
          wdog_d     = '0;
        end
      end
      ISSUE: begin
        wdog_d = wdog_q + 1'b1;
        if (f_in_hs) begin
          f_in_vld_d  = 1'b0;
          f_out_rdy_d = 1'b1;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (f_out_hs) begin
          f_out_rdy_d         = 1'b0;
          out_data_d[owner_q] = bus.f_out_data;
          out_err_d[owner_q]  = bus.f_err;
          out_vld_d[owner_q]  = 1'b1;
          arb_err_d[2:0]      = arb_err_d[2:0] | bus.f_err;
        end
      end
      RESP: begin
        if (owner_rdy) begin
          out_vld_d[owner_q] = 1'b0;
          last_d             = owner_q;
        end
      end
      default: ;
    endcase

    // Watchdog abort: return a zero result flagged 111 to the owner.
    if (abort) begin
      f_in_vld_d          = 1'b0;
      f_out_rdy_d         = 1'b0;
      out_data_d[owner_q] = '0;
      out_err_d[owner_q]  = 3'b111;
      out_vld_d[owner_q]  = 1'b1;
      arb_err_d[3]        = 1'b1;
    end
  end

  // NOTE: result registers are reset too, so a requester never sees stale data after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      f_ope_q       <= '0;
      f_in1_q       <= '0;
      f_in2_q       <= '0;
      f_in_vld_q    <= 1'b0;
      f_out_rdy_q   <= 1'b0;
      out_data_q[0] <= '0;
      out_data_q[1] <= '0;
      out_err_q[0]  <= '0;
      out_err_q[1]  <= '0;
      out_vld_q     <= '0;
      arb_err_q     <= '0;
      wdog_q        <= '0;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      f_ope_q     <= f_ope_d;
      f_in1_q     <= f_in1_d;
      f_in2_q     <= f_in2_d;
      f_in_vld_q  <= f_in_vld_d;
      f_out_rdy_q <= f_out_rdy_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_vld_q   <= out_vld_d;
      arb_err_q   <= arb_err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.r0_in_rdy   = in_rdy[0];
  assign bus.r1_in_rdy   = in_rdy[1];
  assign bus.r0_out_data = out_data_q[0];
  assign bus.r1_out_data = out_data_q[1];
  assign bus.r0_out_err  = out_err_q[0];
  assign bus.r1_out_err  = out_err_q[1];
  assign bus.r0_out_vld  = out_vld_q[0];
  assign bus.r1_out_vld  = out_vld_q[1];
  assign bus.f_ope_data  = f_ope_q;
  assign bus.f_in1_data  = f_in1_q;
  assign bus.f_in2_data  = f_in2_q;
  assign bus.f_in_vld    = f_in_vld_q;
  assign bus.f_out_rdy   = f_out_rdy_q;
  assign arb_err         = arb_err_q;
endmodule
